// File: rtl/history_read_arbiter.sv
// history_read_arbiter
//   Round-robin arbiter that shares the single unaligned read port of the
//   history-window memory among NUM_REQ match engines. It also forwards the
//   aligned write stream from the window loader. Read data comes back one cycle
//   after the grant, tagged with a one-hot resp_valid.
//
// Optional feature macro: HISTORY_ARB_RAW_STALL_EN
//   When this macro is defined, a read whose two touched lines collide with the
//   same-cycle write is held off for that cycle. The same winner retries on the
//   next cycle. When the macro is undefined, reads always issue and a colliding
//   read returns the data from before the write.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   req_valid/addr     per-requester read request; requester i addr at slice i
//   req_ready          one-hot grant (handshake = valid & ready)
//   resp_valid/data    one-hot owner of the shared read-data bus, 1 cycle after grant
//   wr_valid/addr/data aligned write from window loader, always accepted
//   mem_write_*        memory write port (pass-through)
//   mem_read_*         memory read port; mem_read_data has 1-cycle latency
module history_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH_BYTES     = 8,
  parameter int SIZE_BYTES_LOG2 = 15
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*SIZE_BYTES_LOG2-1:0] req_addr,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic [WIDTH_BYTES*8-1:0]           resp_data,
  input  logic                               wr_valid,
  input  logic [SIZE_BYTES_LOG2-1:0]         wr_addr,
  input  logic [WIDTH_BYTES*8-1:0]           wr_data,
  output logic                               mem_write_enable,
  output logic [SIZE_BYTES_LOG2-1:0]         mem_write_address,
  output logic [WIDTH_BYTES*8-1:0]           mem_write_data,
  output logic                               mem_read_enable,
  output logic [SIZE_BYTES_LOG2-1:0]         mem_read_address,
  input  logic [WIDTH_BYTES*8-1:0]           mem_read_data
);

  localparam int AW     = SIZE_BYTES_LOG2;
  localparam int OFF_W  = $clog2(WIDTH_BYTES);
  localparam int LINE_W = AW - OFF_W;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0][AW-1:0] addr;
  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           win;
  logic                       found;
  logic                       hazard;
  logic                       grant;
  logic [AW-1:0]              win_addr;
  int                         cand;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr[i] = req_addr[i*AW +: AW];
  end

  // Search the requesters starting just after the last winner. The first valid
  // requester found in that order is the winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = PTR_W'(cand);
      end
    end
  end

  assign win_addr = addr[win];

`ifdef HISTORY_ARB_RAW_STALL_EN
  logic [LINE_W-1:0] win_line, win_line_nxt, wr_line;
  assign win_line     = win_addr[AW-1:OFF_W];
  // An unaligned read also touches the next line. The top line wraps to line 0.
  assign win_line_nxt = win_line + LINE_W'(1);
  assign wr_line      = wr_addr[AW-1:OFF_W];
  assign hazard       = wr_valid && ((wr_line == win_line) || (wr_line == win_line_nxt));
`else
  assign hazard = 1'b0;
`endif

  // req_ready is forced to 0 while rst_n is low.
  assign grant = rst_n && found && !hazard;

  assign req_ready        = grant ? (NUM_REQ'(1) << win) : '0;
  assign mem_read_enable  = grant;
  assign mem_read_address = win_addr;
  assign resp_data        = mem_read_data;

  assign mem_write_enable  = rst_n && wr_valid;
  assign mem_write_address = wr_addr;
  assign mem_write_data    = wr_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= PTR_W'(NUM_REQ - 1);
      resp_valid <= '0;
    end else begin
      resp_valid <= req_ready;
      if (grant) rr_ptr <= win;
    end
  end

endmodule

// File: tb/tb_history_read_arbiter.sv
module tb_history_read_arbiter;
  localparam int NR = 4;
  localparam int WB = 8;
  localparam int AW = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     resp_valid;
  logic [WB*8-1:0]   resp_data;
  logic              wr_valid;
  logic [AW-1:0]     wr_addr;
  logic [WB*8-1:0]   wr_data;
  logic              mem_write_enable;
  logic [AW-1:0]     mem_write_address;
  logic [WB*8-1:0]   mem_write_data;
  logic              mem_read_enable;
  logic [AW-1:0]     mem_read_address;
  logic [WB*8-1:0]   mem_read_data;

  int checks = 0;
  int errors = 0;

  history_read_arbiter #(.NUM_REQ(NR), .WIDTH_BYTES(WB), .SIZE_BYTES_LOG2(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Unaligned 1R1W memory model. The read captures old contents before the
  // same-edge write lands.
  logic [7:0] mem [0:(1<<AW)-1];
  logic       preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 8'(i);
    end else begin
      if (mem_read_enable)
        for (int b = 0; b < WB; b++) mem_read_data[b*8 +: 8] <= mem[AW'(mem_read_address + AW'(b))];
      if (mem_write_enable)
        for (int b = 0; b < WB; b++) mem[{mem_write_address[AW-1:3], 3'(b)}] <= mem_write_data[b*8 +: 8];
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_addr(input int r, input logic [AW-1:0] a);
    req_addr[r*AW +: AW] = a;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 4'b1111; wr_valid = 1'b0;
    tick; tick;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++;
    if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp got %b want 0000", resp_valid); end
    checks++;
    if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", mem_read_enable); end
    checks++;
    if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", mem_write_enable); end
  endtask

  task automatic test_round_robin;
    logic [NR-1:0] exp_g [0:4];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    req_valid = 4'b1111;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (req_ready !== exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, exp_g[k]); end
      checks++;
      if (k == 0) begin
        if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rr_resp[0] got %b want 0000", resp_valid); end
      end else begin
        if (resp_valid !== exp_g[k-1]) begin errors++; $display("FAIL rr_resp[%0d] got %b want %b", k, resp_valid, exp_g[k-1]); end
      end
      tick;
    end
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 4'b0001) begin errors++; $display("FAIL rr_resp_last got %b want 0001", resp_valid); end
    tick;
  endtask

  task automatic test_single;
    req_valid = 4'b0100; set_addr(2, 15'h0005);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    checks++;
    if (mem_read_enable !== 1'b1 || mem_read_address !== 15'h0005) begin
      errors++; $display("FAIL single_rd got en=%b addr=%h want en=1 addr=0005", mem_read_enable, mem_read_address);
    end
    tick;
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 4'b0100) begin errors++; $display("FAIL single_resp got %b want 0100", resp_valid); end
    checks++;
    if (resp_data !== 64'h0C0B0A0908070605) begin errors++; $display("FAIL single_data got %h want 0c0b0a0908070605", resp_data); end
    checks++;
    if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL idle_rd_en got %b want 0", mem_read_enable); end
    tick;
    checks++;
    if (resp_valid !== 4'b0000) begin errors++; $display("FAIL idle_resp got %b want 0000", resp_valid); end
  endtask

  task automatic test_wrap;
    req_valid = 4'b1000; set_addr(3, 15'h7FFC);
    #1;
    checks++;
    if (req_ready !== 4'b1000 || mem_read_address !== 15'h7FFC) begin
      errors++; $display("FAIL wrap_grant got ready=%b addr=%h want 1000 7ffc", req_ready, mem_read_address);
    end
    tick;
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 4'b1000 || resp_data !== 64'h03020100FFFEFDFC) begin
      errors++; $display("FAIL wrap_data got v=%b d=%h want 1000 03020100fffefdfc", resp_valid, resp_data);
    end
    tick;
  endtask

  task automatic test_raw;
    // Write and read to different lines: both issue in the same cycle.
    req_valid = 4'b0010; set_addr(1, 15'h000C);
    wr_valid = 1'b1; wr_addr = 15'h0100; wr_data = 64'h1122334455667788;
    #1;
    checks++;
    if (req_ready !== 4'b0010 || mem_read_enable !== 1'b1 || mem_write_enable !== 1'b1) begin
      errors++; $display("FAIL raw_nohaz got ready=%b rd=%b wr=%b want 0010 1 1", req_ready, mem_read_enable, mem_write_enable);
    end
    tick;
    req_valid = '0; wr_valid = 1'b0;
    tick;
    // Read lines 1,2 and write line 2 in the same cycle.
    req_valid = 4'b0010; set_addr(1, 15'h000C);
    wr_valid = 1'b1; wr_addr = 15'h0010; wr_data = 64'hA1A2A3A4A5A6A7A8;
    #1;
    checks++;
    if (mem_write_enable !== 1'b1 || mem_write_address !== 15'h0010 || mem_write_data !== 64'hA1A2A3A4A5A6A7A8) begin
      errors++; $display("FAIL raw_wr got en=%b a=%h d=%h want 1 0010 a1a2a3a4a5a6a7a8", mem_write_enable, mem_write_address, mem_write_data);
    end
`ifdef HISTORY_ARB_RAW_STALL_EN
    checks++;
    if (req_ready !== 4'b0000 || mem_read_enable !== 1'b0) begin
      errors++; $display("FAIL raw_stall got ready=%b rd=%b want 0000 0", req_ready, mem_read_enable);
    end
    tick;
    wr_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL raw_retry got %b want 0010", req_ready); end
    tick;
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 4'b0010 || resp_data !== 64'hA5A6A7A80F0E0D0C) begin
      errors++; $display("FAIL raw_data got v=%b d=%h want 0010 a5a6a7a80f0e0d0c", resp_valid, resp_data);
    end
`else
    checks++;
    if (req_ready !== 4'b0010 || mem_read_enable !== 1'b1) begin
      errors++; $display("FAIL raw_nostall got ready=%b rd=%b want 0010 1", req_ready, mem_read_enable);
    end
    tick;
    req_valid = '0; wr_valid = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 4'b0010 || resp_data !== 64'h131211100F0E0D0C) begin
      errors++; $display("FAIL raw_data got v=%b d=%h want 0010 131211100f0e0d0c", resp_valid, resp_data);
    end
`endif
    tick;
  endtask

  task automatic test_reset_mid;
    req_valid = 4'b1111;
    tick; tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b want 0000", req_ready); end
    tick;
    checks++;
    if (resp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_rst_resp got v=%b r=%b want 0000 0000", resp_valid, req_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rst_first got %b want 0001", req_ready); end
    tick;
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 4'b0001) begin errors++; $display("FAIL mid_rst_resp1 got %b want 0001", resp_valid); end
    tick;
  endtask

  task automatic test_write_stream;
    logic [63:0] d;
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      d = {32'hC0DE0000 + 32'(i), 32'(i) * 32'h01010101};
      wr_valid = 1'b1; wr_addr = AW'(i * 8); wr_data = d;
      #1;
      checks++;
      if (mem_write_enable !== 1'b1 || mem_write_address !== AW'(i * 8) || mem_write_data !== d) begin
        errors++; $display("FAIL wstream[%0d] got en=%b a=%h d=%h want 1 %h %h", i, mem_write_enable, mem_write_address, mem_write_data, AW'(i * 8), d);
      end
      checks++;
      if (resp_valid !== 4'b0000 || mem_read_enable !== 1'b0) begin
        errors++; $display("FAIL wstream_rd[%0d] got v=%b rd=%b want 0000 0", i, resp_valid, mem_read_enable);
      end
      tick;
    end
    wr_valid = 1'b0;
    #1;
    checks++;
    if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL wstream_end got %b want 0", mem_write_enable); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    preload = 1'b1;
    tick;
    preload = 1'b0;
    test_reset;
    test_round_robin;
    test_single;
    test_wrap;
    test_raw;
    test_reset_mid;
    test_write_stream;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
